// File: rtl/dmem_circ_reader.sv
// dmem_circ_reader: circular-buffer read stream engine feeding the DSP datapath.
// Define DMEM_RD_REVERSE_EN to add the `reverse` input for backward stepping.
module dmem_circ_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] buf_len,
  input  logic [ADDR_WIDTH-1:0] start_off,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  count,
`ifdef DMEM_RD_REVERSE_EN
  input  logic                  reverse,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ADDR_WIDTH-1:0] off;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  issued;
  logic [CNT_WIDTH-1:0]  emitted;
  logic                  rvalid;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wp;
  logic                  rp;
  logic [1:0]            fcnt;

  logic                  idle;
  logic [ADDR_WIDTH-1:0] c_base;
  logic [ADDR_WIDTH-1:0] c_len;
  logic [ADDR_WIDTH-1:0] c_stride;
  logic [ADDR_WIDTH-1:0] c_off;
  logic [ADDR_WIDTH:0]   fwd_sum;
  logic [ADDR_WIDTH-1:0] fwd_next;
  logic [ADDR_WIDTH-1:0] step;
  logic [2:0]            occ;
  logic                  room;
  logic                  issue;
  logic                  fifo_empty;
  logic                  pop;
  logic                  pop_f;
  logic                  push;

  // In IDLE the first read is issued straight from the command inputs.
  assign idle     = (state == S_IDLE);
  assign c_base   = idle ? base_addr : base_q;
  assign c_len    = idle ? buf_len   : len_q;
  assign c_stride = idle ? stride    : stride_q;
  assign c_off    = idle ? start_off : off;

  assign fwd_sum  = {1'b0, c_off} + {1'b0, c_stride};
  assign fwd_next = ADDR_WIDTH'((fwd_sum >= {1'b0, c_len}) ?
                                fwd_sum - {1'b0, c_len} : fwd_sum);

`ifdef DMEM_RD_REVERSE_EN
  logic                  rev_q;
  logic                  c_rev;
  logic [ADDR_WIDTH-1:0] bwd_next;

  assign c_rev    = idle ? reverse : rev_q;
  assign bwd_next = (c_off < c_stride) ?
    ADDR_WIDTH'({1'b0, c_off} + {1'b0, c_len} - {1'b0, c_stride}) :
    c_off - c_stride;
  assign step     = c_rev ? bwd_next : fwd_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rev_q <= 1'b0;
    end else if (idle && start) begin
      rev_q <= reverse;
    end
  end
`else
  assign step = fwd_next;
`endif

  assign fifo_empty = (fcnt == 2'd0);
  assign out_valid  = !fifo_empty || rvalid;
  assign out_data   = !fifo_empty ? fifo_mem[rp] :
                      (rvalid ? mem_rdata : '0);
  assign out_last   = out_valid && (emitted == cnt_q - CNT_WIDTH'(1));
  assign pop        = out_valid && out_ready;
  assign pop_f      = pop && !fifo_empty;
  assign push       = rvalid && !(fifo_empty && pop);

  // Words held or heading for the FIFO after this edge must fit in 2 slots.
  assign occ   = {1'b0, fcnt} + {2'b0, rvalid} + {2'b0, mem_en};
  assign room  = occ < (3'd2 + {2'b0, pop});
  assign issue = idle ? (start && (count != '0)) :
                 ((state == S_RUN) && (issued != cnt_q) && room);

  assign busy = !idle;
  assign done = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      stride_q <= '0;
      off      <= '0;
      cnt_q    <= '0;
      issued   <= '0;
      emitted  <= '0;
      mem_addr <= '0;
      mem_en   <= 1'b0;
      rvalid   <= 1'b0;
    end else begin
      mem_en <= issue;
      rvalid <= mem_en;
      if (issue) begin
        mem_addr <= c_base + c_off;
        off      <= step;
      end
      if (pop) begin
        emitted <= emitted + CNT_WIDTH'(1);
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= buf_len;
            stride_q <= stride;
            cnt_q    <= count;
            issued   <= CNT_WIDTH'(issue);
            emitted  <= '0;
            state    <= (count == '0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            issued <= issued + CNT_WIDTH'(1);
          end
          if (issued == cnt_q) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((pop && out_last) || (emitted == cnt_q)) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp   <= 1'b0;
      rp   <= 1'b0;
      fcnt <= 2'd0;
    end else begin
      if (push) begin
        wp <= ~wp;
      end
      if (pop_f) begin
        rp <= ~rp;
      end
      fcnt <= fcnt + {1'b0, push} - {1'b0, pop_f};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wp] <= mem_rdata;
    end
  end

endmodule
